// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the MEM-stage data-memory responder.
// Optional feature macro used by this slice: DMEM_BYTE_EN_EN (RAM byte enables).
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam int LANE_W  = 8;
    localparam int N_LANES = 4;

    // Lane bit 3 covers [31:24]: big-endian byte 0 sits in the top lane.
    localparam logic [3:0] LANE_BYTE0   = 4'b1000;
    localparam logic [3:0] LANE_HALF_HI = 4'b1100;
    localparam logic [3:0] LANE_HALF_LO = 4'b0011;
    localparam logic [3:0] LANE_ALL     = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_WR,
        ST_RESP,
        ST_ERR
    } state_e;

    function automatic logic size_addr_bad(input logic [1:0] size, input logic [1:0] off);
        return (size == SZ_ILL) ||
               ((size == SZ_HALF) && off[0]) ||
               ((size == SZ_WORD) && (off != 2'b00));
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return LANE_BYTE0 >> off;
            SZ_HALF: return off[1] ? LANE_HALF_LO : LANE_HALF_HI;
            SZ_WORD: return LANE_ALL;
            default: return 4'b0000;
        endcase
    endfunction

    // Right-shift that brings the addressed lane down to bit 0.
    function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return {~off, 3'b000};
            SZ_HALF: return {~off[1], 4'b0000};
            default: return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_mux.sv
// Combinational big-endian lane extract (with zero/sign extension) and
// lane merge for read-modify-write stores.
module dmem_lane_mux
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] extract_o,
    output logic [31:0] merge_o
);

    logic [4:0]  shamt;
    logic [3:0]  mask;
    logic [31:0] shifted_rd;
    logic [31:0] shifted_wd;

    assign shamt      = lane_shift(size_i, addr_i);
    assign mask       = lane_mask(size_i, addr_i);
    assign shifted_rd = word_i >> shamt;
    assign shifted_wd = wdata_i << shamt;

    always_comb begin
        extract_o = shifted_rd;
        case (size_i)
            SZ_BYTE: extract_o = {{24{signed_i & shifted_rd[7]}}, shifted_rd[7:0]};
            SZ_HALF: extract_o = {{16{signed_i & shifted_rd[15]}}, shifted_rd[15:0]};
            default: extract_o = shifted_rd;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_LANES; gi++) begin : g_lane
            assign merge_o[gi*LANE_W +: LANE_W] = mask[gi] ? shifted_wd[gi*LANE_W +: LANE_W]
                                                           : word_i[gi*LANE_W +: LANE_W];
        end
    endgenerate

endmodule

// File: rtl/dmem_rmw_ctrl.sv
// MEM-stage data-memory responder: one request at a time, RMW for sub-word stores.
// Optional macro DMEM_BYTE_EN_EN adds ram_be and turns sub-word stores into single writes.
module dmem_rmw_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
`ifdef DMEM_BYTE_EN_EN
    ,
    output logic [3:0]        ram_be
`endif
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        off_q, off_d;
    logic [1:0]        size_q, size_d;
    logic              we_q, we_d;
    logic              signed_q, signed_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       extract_w;
    logic [31:0]       merge_w;
`ifdef DMEM_BYTE_EN_EN
    logic [3:0]        be_q, be_d;
`endif

    dmem_lane_mux u_lane_mux (
        .word_i    (ram_rdata),
        .addr_i    (off_q),
        .size_i    (size_q),
        .signed_i  (signed_q),
        .wdata_i   (wdata_q),
        .extract_o (extract_w),
        .merge_o   (merge_w)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            off_q    <= '0;
            size_q   <= '0;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
`ifdef DMEM_BYTE_EN_EN
            be_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            off_q    <= off_d;
            size_q   <= size_d;
            we_q     <= we_d;
            signed_q <= signed_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
`ifdef DMEM_BYTE_EN_EN
            be_q     <= be_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        off_d    = off_q;
        size_d   = size_q;
        we_d     = we_q;
        signed_d = signed_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
`ifdef DMEM_BYTE_EN_EN
        be_d     = be_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr[ADDR_W+1:2];
                    off_d    = req_addr[1:0];
                    size_d   = req_size;
                    we_d     = req_we;
                    signed_d = req_signed;
                    wdata_d  = req_wdata;
`ifdef DMEM_BYTE_EN_EN
                    be_d     = req_we ? lane_mask(req_size, req_addr[1:0]) : 4'b0000;
`endif
                    if (size_addr_bad(req_size, req_addr[1:0])) begin
                        rdata_d = '0;
                        state_d = ST_ERR;
                    end else if (req_we && (req_size == SZ_WORD)) begin
                        state_d = ST_WR;
`ifdef DMEM_BYTE_EN_EN
                    end else if (req_we) begin
                        // Replicate so every lane carries the data; byte enables pick the lane.
                        wdata_d = (req_size == SZ_BYTE) ? {4{req_wdata[7:0]}} : {2{req_wdata[15:0]}};
                        state_d = ST_WR;
`endif
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD:   state_d = ST_WAIT;
            ST_WAIT: begin
                if (we_q) begin
                    wdata_d = merge_w;
                    state_d = ST_WR;
                end else begin
                    rdata_d = extract_w;
                    state_d = ST_RESP;
                end
            end
            ST_WR: begin
                rdata_d = '0;
                state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // rst masks strobes in the reset cycle so an in-flight write is dropped.
    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = ((state_q == ST_RESP) || (state_q == ST_ERR)) && !rst;
    assign rsp_err   = (state_q == ST_ERR) && !rst;
    assign rsp_rdata = rdata_q;
    assign ram_en    = ((state_q == ST_RD) || (state_q == ST_WR)) && !rst;
    assign ram_we    = (state_q == ST_WR) && !rst;
    assign ram_addr  = addr_q;
    assign ram_wdata = (state_q == ST_WR) ? wdata_q : '0;
`ifdef DMEM_BYTE_EN_EN
    assign ram_be    = ((state_q == ST_WR) && !rst) ? be_q : 4'b0000;
`endif

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Self-checking bench for dmem_rmw_ctrl: directed table, corner sequences, random vs byte model.
module tb_dmem_rmw_ctrl;
    import dmem_pkg::*;

    localparam int ADDR_W = 30;
`ifdef DMEM_BYTE_EN_EN
    localparam int SUB_LAT = 2;
    localparam int SUB_EN  = 1;
`else
    localparam int SUB_LAT = 4;
    localparam int SUB_EN  = 2;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_we, req_signed;
    logic [1:0]        req_size;
    logic [31:0]       req_addr, req_wdata;
    logic              rsp_valid, rsp_err;
    logic [31:0]       rsp_rdata;
    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
`ifdef DMEM_BYTE_EN_EN
    logic [3:0]        ram_be;
`endif

    always #5 clk = ~clk;

    dmem_rmw_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef DMEM_BYTE_EN_EN
        , .ram_be(ram_be)
`endif
    );

    // Single-port synchronous RAM, 1-cycle read latency.
    logic [31:0] tb_ram [0:255];
    int          addr_oob = 0;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_addr[ADDR_W-1:8] != '0) addr_oob <= addr_oob + 1;
            if (ram_we) begin
`ifdef DMEM_BYTE_EN_EN
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) tb_ram[ram_addr[7:0]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
`else
                tb_ram[ram_addr[7:0]] <= ram_wdata;
`endif
            end else begin
                ram_rdata <= tb_ram[ram_addr[7:0]];
            end
        end
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Byte-addressed reference memory, big-endian.
    logic [7:0] ref_mem [0:1023];

    task automatic model(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat,
                         output int nen, output int nwr);
        int nb;
        int base;
        logic [31:0] v;
        er  = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
        rd  = '0; nen = 0; nwr = 0; lat = 1;
        base = int'(a[9:0]);
        if (!er) begin
            nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            if (we) begin
                for (int k = 0; k < nb; k++) ref_mem[base+k] = wd[8*(nb-1-k) +: 8];
                nwr = 1;
                lat = (nb == 4) ? 2 : SUB_LAT;
                nen = (nb == 4) ? 1 : SUB_EN;
            end else begin
                v = '0;
                for (int k = 0; k < nb; k++) v = (v << 8) | {24'd0, ref_mem[base+k]};
                if (sg && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
                rd  = v;
                lat = 3;
                nen = 1;
            end
        end
    endtask

    // Issue one request from a negedge; returns one cycle after the response.
    task automatic xact(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat,
                        output int nen, output int nwr, output logic [31:0] wlast,
                        output int wlat, output logic [3:0] wbe);
        int waitc;
        rd = '0; er = 1'b0; lat = 0; nen = 0; nwr = 0; wlast = '0; wlat = 0; wbe = '0;
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        waitc = 0;
        while (!req_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (1) begin
            if (ram_en) nen++;
            if (ram_we) begin
                nwr++;
                wlast = ram_wdata;
                wlat  = lat;
`ifdef DMEM_BYTE_EN_EN
                wbe   = ram_be;
`endif
            end
            if (rsp_valid) begin
                rd = rsp_rdata;
                er = rsp_err;
                break;
            end
            if (lat >= 20) begin
                chk("rsp_timeout", 32'(rsp_valid), 32'd1);
                break;
            end
            @(negedge clk);
            lat++;
        end
        $display("xact we=%0d sz=%0d sg=%0d addr=%h wd=%h -> rd=%h err=%0d lat=%0d en=%0d wr=%0d",
                 we, sz, sg, a, wd, rd, er, lat, nen, nwr);
        @(negedge clk);
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string n, input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] erd,
                       input logic eer, input int el);
        vec_t v;
        v.name = n; v.we = we; v.sz = sz; v.sg = sg; v.addr = a; v.wd = wd;
        v.exp_rd = erd; v.exp_err = eer; v.exp_lat = el;
        tbl.push_back(v);
    endtask

    initial begin
        logic [31:0] rd, erd, wl;
        logic        er, eer;
        int          lat, nen, nwr, wlat, elat, enen, enwr, cnt_we, cnt_rv;
        logic [3:0]  wbe;
        logic        we;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] a, wd;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err",   32'(rsp_err), 32'd0);
        chk("rst_ram_en",    32'(ram_en), 32'd0);
        chk("rst_ram_we",    32'(ram_we), 32'd0);
        chk("rst_ram_addr",  32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);

        add("sw_init1", 1, SZ_WORD, 0, 32'h100, 32'h1122_33F4, 32'h0, 0, 2);
        add("lb_s_103", 0, SZ_BYTE, 1, 32'h103, 32'h0, 32'hFFFF_FFF4, 0, 3);
        add("lbu_103",  0, SZ_BYTE, 0, 32'h103, 32'h0, 32'h0000_00F4, 0, 3);
        add("lb_s_100", 0, SZ_BYTE, 1, 32'h100, 32'h0, 32'h0000_0011, 0, 3);
        add("sw_init3", 1, SZ_WORD, 0, 32'h100, 32'h1122_F344, 32'h0, 0, 2);
        add("lh_102",   0, SZ_HALF, 1, 32'h102, 32'h0, 32'hFFFF_F344, 0, 3);
        add("lhu_102",  0, SZ_HALF, 0, 32'h102, 32'h0, 32'h0000_F344, 0, 3);
        add("lh_100",   0, SZ_HALF, 1, 32'h100, 32'h0, 32'h0000_1122, 0, 3);
        add("sh_101",   1, SZ_HALF, 0, 32'h101, 32'h1234, 32'h0, 1, 1);
        add("lw_102",   0, SZ_WORD, 0, 32'h102, 32'h0, 32'h0, 1, 1);
        add("ill_size", 0, SZ_ILL,  0, 32'h100, 32'h0, 32'h0, 1, 1);
        add("sb_102",   1, SZ_BYTE, 0, 32'h102, 32'hFFFF_FF7E, 32'h0, 0, SUB_LAT);
        add("lw_100",   0, SZ_WORD, 1, 32'h100, 32'h0, 32'h1122_7E44, 0, 3);
        add("sh_100",   1, SZ_HALF, 0, 32'h100, 32'h0000_BEEF, 32'h0, 0, SUB_LAT);
        add("lw_100b",  0, SZ_WORD, 0, 32'h100, 32'h0, 32'hBEEF_7E44, 0, 3);

        foreach (tbl[i]) begin
            xact(tbl[i].we, tbl[i].sz, tbl[i].sg, tbl[i].addr, tbl[i].wd,
                 rd, er, lat, nen, nwr, wl, wlat, wbe);
            enen = tbl[i].exp_err ? 0 : (tbl[i].we && tbl[i].sz != SZ_WORD) ? SUB_EN : 1;
            enwr = (tbl[i].exp_err || !tbl[i].we) ? 0 : 1;
            chk({tbl[i].name, "_rdata"}, rd, tbl[i].exp_rd);
            chk({tbl[i].name, "_err"},   32'(er), 32'(tbl[i].exp_err));
            chk({tbl[i].name, "_lat"},   lat, tbl[i].exp_lat);
            chk({tbl[i].name, "_ram_en"}, nen, enen);
            chk({tbl[i].name, "_ram_we"}, nwr, enwr);
            chk({tbl[i].name, "_hold"},  rsp_rdata, tbl[i].exp_rd);
        end

        // Sub-word store write timing and data.
        xact(1, SZ_WORD, 0, 32'h100, 32'h1122_3344, rd, er, lat, nen, nwr, wl, wlat, wbe);
        xact(1, SZ_BYTE, 0, 32'h101, 32'h0000_00AA, rd, er, lat, nen, nwr, wl, wlat, wbe);
        chk("sb101_lat", lat, SUB_LAT);
        chk("sb101_nwr", nwr, 1);
`ifdef DMEM_BYTE_EN_EN
        chk("sb101_wlat", wlat, 1);
        chk("sb101_wdata", wl, 32'hAAAA_AAAA);
        chk("sb101_be", 32'(wbe), 32'h4);
`else
        chk("sb101_wlat", wlat, 3);
        chk("sb101_wdata", wl, 32'h11AA_3344);
`endif
        xact(0, SZ_WORD, 0, 32'h100, 32'h0, rd, er, lat, nen, nwr, wl, wlat, wbe);
        chk("sb101_readback", rd, 32'h11AA_3344);

        // Reset during a sub-word store.
        xact(1, SZ_WORD, 0, 32'h100, 32'h1122_3344, rd, er, lat, nen, nwr, wl, wlat, wbe);
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_BYTE; req_signed = 1'b0;
        req_addr = 32'h101; req_wdata = 32'h0000_00AA;
        @(negedge clk);
        req_valid = 1'b0;
        cnt_we = 0; cnt_rv = 0;
`ifndef DMEM_BYTE_EN_EN
        if (ram_we) cnt_we++;
        if (rsp_valid) cnt_rv++;
        @(negedge clk);
`endif
        rst = 1'b1;
        #1;
        if (ram_we) cnt_we++;
        if (rsp_valid) cnt_rv++;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_ready", 32'(req_ready), 32'd1);
        for (int k = 0; k < 5; k++) begin
            if (ram_we) cnt_we++;
            if (rsp_valid) cnt_rv++;
            @(negedge clk);
        end
        chk("rstmid_no_we", cnt_we, 0);
        chk("rstmid_no_rsp", cnt_rv, 0);
        $display("xact reset mid-store: we_pulses=%0d rsp_pulses=%0d", cnt_we, cnt_rv);
        xact(0, SZ_WORD, 0, 32'h100, 32'h0, rd, er, lat, nen, nwr, wl, wlat, wbe);
        chk("rstmid_ram_unchanged", rd, 32'h1122_3344);
        chk("rstmid_lw_lat", lat, 3);

        // Back-to-back with req_valid held high.
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD; req_signed = 1'b0;
        req_addr = 32'h200; req_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_sw_lat", lat, 2);
        req_we = 1'b0; req_addr = 32'h200; req_wdata = 32'h0;
        @(negedge clk);
        chk("b2b_ready_after_rsp", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_accepted", 32'(req_ready), 32'd0);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_lw_lat", lat, 3);
        chk("b2b_lw_rdata", rsp_rdata, 32'hDEAD_BEEF);
        $display("xact back-to-back SW/LW @200: lw rd=%h lat=%0d", rsp_rdata, lat);
        @(negedge clk);

        xact(1, SZ_BYTE, 0, 32'h202, 32'h0000_005A, rd, er, lat, nen, nwr, wl, wlat, wbe);
        chk("sb202_lat", lat, SUB_LAT);
`ifdef DMEM_BYTE_EN_EN
        chk("sb202_be", 32'(wbe), 32'h2);
        chk("sb202_wlat", wlat, 1);
`endif
        xact(0, SZ_WORD, 0, 32'h200, 32'h0, rd, er, lat, nen, nwr, wl, wlat, wbe);
        chk("sb202_readback", rd, 32'hDEAD_5AEF);

        // Random traffic against the byte model over words 0x300..0x33F.
        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            a  = 32'h300 + 32'(w * 4);
            model(1, SZ_WORD, 0, a, wd, erd, eer, elat, enen, enwr);
            xact(1, SZ_WORD, 0, a, wd, rd, er, lat, nen, nwr, wl, wlat, wbe);
        end
        for (int n = 0; n < 150; n++) begin
            int r;
            we = 1'($urandom_range(0, 1));
            r  = int'($urandom_range(0, 9));
            sz = (r < 3) ? SZ_BYTE : (r < 6) ? SZ_HALF : (r < 9) ? SZ_WORD : SZ_ILL;
            sg = 1'($urandom_range(0, 1));
            a  = 32'h300 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == SZ_HALF) a[0] = 1'b0;
                if (sz == SZ_WORD) a[1:0] = 2'b00;
            end
            wd = $urandom;
            model(we, sz, sg, a, wd, erd, eer, elat, enen, enwr);
            xact(we, sz, sg, a, wd, rd, er, lat, nen, nwr, wl, wlat, wbe);
            chk("rnd_rdata", rd, erd);
            chk("rnd_err", 32'(er), 32'(eer));
            chk("rnd_lat", lat, elat);
            chk("rnd_ram_en", nen, enen);
            chk("rnd_ram_we", nwr, enwr);
        end
        for (int w = 0; w < 16; w++) begin
            a = 32'h300 + 32'(w * 4);
            model(0, SZ_WORD, 0, a, 32'h0, erd, eer, elat, enen, enwr);
            xact(0, SZ_WORD, 0, a, 32'h0, rd, er, lat, nen, nwr, wl, wlat, wbe);
            chk("rnd_final_word", rd, erd);
        end
        chk("ram_addr_range", addr_oob, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
